iob_clint_mtime: RTL



---
 rtl/iob_clint_pkg.sv | 18 +
 rtl/iob_clint_mtime_if.sv | 12 +
 rtl/iob_clint_rtc_sync.sv | 30 +++
 rtl/iob_clint_mtime.sv | 60 ++++++
 4 files changed

// File: rtl/iob_clint_pkg.sv
// iob_clint_pkg: constants and helpers shared by the CLINT blocks (mtime, mtimecmp, msip) and their benches.
package iob_clint_pkg;
    localparam logic [15:0] MTIME_LO_ADDR = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_ADDR = 16'hBFFC;
    localparam int MTIME_W = 64;
    localparam int BUS_DATA_W = 32;

    // Replace each strobed byte of cur with the matching byte of nw.
    function automatic logic [BUS_DATA_W-1:0] byte_merge(
        input logic [BUS_DATA_W-1:0] cur,
        input logic [BUS_DATA_W-1:0] nw,
        input logic [BUS_DATA_W/8-1:0] strb
    );
        logic [BUS_DATA_W-1:0] r;
        for (int i = 0; i < BUS_DATA_W / 8; i++) r[i*8+:8] = strb[i] ? nw[i*8+:8] : cur[i*8+:8];
        return r;
    endfunction
endpackage

// File: rtl/iob_clint_mtime_if.sv
// iob_clint_mtime_if: 32-bit register access bus for the mtime block.
// valid/word_sel/wdata/wstrb driven by the master, rdata/ready returned by the slave.
interface iob_clint_mtime_if #(parameter int DATA_W = 32);
    logic              valid;
    logic              word_sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    modport master (output valid, word_sel, wdata, wstrb, input rdata, ready);
    modport slave (input valid, word_sel, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_clint_rtc_sync.sv
// iob_clint_rtc_sync: brings rtc into the clk domain and emits a one-cycle rtc_rise per rising edge.
// Ports: clk, rst (async, active-high), rtc (async input), rtc_rise (pulse).
module iob_clint_rtc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rtc,
    output logic rtc_rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic edge_q;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            edge_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            // On the arming cycle the whole chain is preloaded with the current rtc level,
            // so an rtc already high at reset release never looks like a rising edge.
            sync <= armed ? {sync[SYNC_STAGES-2:0], rtc} : {SYNC_STAGES{rtc}};
            edge_q <= armed ? sync[SYNC_STAGES-1] : rtc;
            armed <= 1'b1;
        end
    end

    assign rtc_rise = armed & sync[SYNC_STAGES-1] & ~edge_q;
endmodule

// File: rtl/iob_clint_mtime.sv
// iob_clint_mtime: 64-bit machine timer counting rtc rising edges, with 32-bit CPU access and atomic lo/hi reads.
// Ports: clk, rst (async, active-high), rtc (async tick source), bus (slave access port),
//        mtime (to the mtimecmp comparators), tick (pulse on each increment).
module iob_clint_mtime
    import iob_clint_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rtc,
    iob_clint_mtime_if.slave   bus,
    output logic [MTIME_W-1:0] mtime,
    output logic               tick
);
    logic rtc_rise;
    logic wr;
    logic rd;
    logic snap_vld;
    logic [DATA_W-1:0] hi_snap;
    logic [DATA_W-1:0] rd_word;
    logic [MTIME_W-1:0] wr_val;

    iob_clint_rtc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .rtc(rtc),
        .rtc_rise(rtc_rise)
    );

    assign wr = bus.valid & |bus.wstrb;
    assign rd = bus.valid & ~|bus.wstrb;
    assign wr_val = bus.word_sel ? {byte_merge(mtime[63:32], bus.wdata, bus.wstrb), mtime[31:0]}
                                 : {mtime[63:32], byte_merge(mtime[31:0], bus.wdata, bus.wstrb)};
    assign rd_word = bus.word_sel ? (snap_vld ? hi_snap : mtime[63:32]) : mtime[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
            tick <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            hi_snap <= '0;
            snap_vld <= 1'b0;
        end else begin
            // A write overrides a coincident rtc edge; that increment is lost.
            mtime <= wr ? wr_val : mtime + MTIME_W'(rtc_rise);
            tick <= rtc_rise & ~wr;
            bus.ready <= bus.valid;
            if (rd) bus.rdata <= rd_word;
            if (wr | (rd & bus.word_sel)) begin
                snap_vld <= 1'b0;
            end else if (rd) begin
                hi_snap <= mtime[63:32];
                snap_vld <= 1'b1;
            end
        end
    end
endmodule
